axi_lite_arbiter_2x1: RTL and testbench
=======================================

# axi_lite_arbiter_2x1

Two-requester AXI-Lite arbiter that shares one downstream AXI-Lite subordinate between two upstream managers. Read and write paths are arbitrated independently. Each path holds its grant from address acceptance through the response handshake, so every transaction completes atomically. It sits between CPU/DMA-style managers and a peripheral register block built on the `axi_lite_interface` bundle.

## Interface
- ADDRESS_WIDTH, 8, read and write address width of all three ports.
- DATA_WIDTH, 8, read and write data width; strobe width is DATA_WIDTH/8. Must be a multiple of 8.

- clk  input  1  single clock for all logic.
- rst_n  input  1  reset, asynchronous assert, active-low.
- s0  axi_lite_interface.Slave  bundle  requester 0 (upstream manager 0).
- s1  axi_lite_interface.Slave  bundle  requester 1 (upstream manager 1).
- m  axi_lite_interface.Master  bundle  shared downstream subordinate.

All three bundles are instantiated with READ/WRITE widths equal to ADDRESS_WIDTH/DATA_WIDTH.

## Operation
- Write FSM states: W_IDLE, W_XFER, W_RESP.
- W_IDLE:
  - Request from requester i means awvalid_i or wvalid_i.
  - On any request, the arbiter picks a winner, registers wgnt, and goes to W_XFER.
- W_XFER:
  - The granted requester's AW and W channels are muxed combinationally to m.
  - Flags aw_done and w_done set on their respective m handshakes.
  - After a channel's flag is set, that channel's m valid and requester ready are forced to 0.
  - When both flags are set (same-cycle completion counts), go to W_RESP.
- W_RESP:
  - m.bresp and m.bvalid go to the granted requester only.
  - m.bready comes from the granted requester's bready.
  - On the B handshake: go to W_IDLE, clear the flags, and set the write priority pointer to the other requester.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: arvalid_i is a request; pick a winner and register rgnt.
  - R_ADDR: forward AR; on handshake go to R_DATA.
  - R_DATA: forward R to the winner. On the R handshake, return to R_IDLE and set the read pointer to the other requester.
- Round-robin pick:
  - Only one requester active: it wins.
  - Both active: the requester named by the pointer wins.
  - Both pointers reset to requester 0.
- Non-granted requester: all of its ready and valid outputs are 0, and its bresp/rresp/rdata are 0.
- Data, address, prot, strb and resp pass through unmodified.
- The arbiter never generates responses itself.
- Read and write FSMs are fully independent. Concurrent read by one requester and write by the other is legal.

## Timing
- Reset values (while rst_n low):
  - Both FSMs in IDLE, pointers = 0, flags = 0.
  - All requester awready/wready/arready/bvalid/rvalid = 0.
  - All m awvalid/wvalid/arvalid/bready/rready = 0.
  - All data/resp outputs = 0.
- Arbitration latency: one cycle. A request seen in IDLE at edge N is forwarded to m starting in cycle N+1.
- No combinational path from requester valid to m valid in IDLE. In granted states, paths are combinational pass-through with zero added latency.
- Minimum write occupancy is 3 cycles (IDLE, XFER, RESP with immediate handshakes). Minimum read occupancy is 3 cycles.
- Requester valids are not required to stay asserted in IDLE. The winner is whichever requester is requesting at the grant edge.
- Reset asserted mid-transaction: FSMs return to IDLE immediately and all valids drop. Downstream transaction integrity is the system's responsibility.
- Back-to-back transfers: after a response handshake there is one IDLE cycle before the next grant.

## Configuration
- AXI_LITE_ARB_FIXED_PRIO_EN:
  - Defined: requester 0 always wins when both request, and the pointers are not implemented.
  - Undefined (default): round-robin as described above.

## Structure
- Package axi_lite_arb_pkg holds:
  - Write and read state enums (w_state_t, r_state_t).
  - Requester index type.
  - AXI response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, for benches.
- Sub-module axi_lite_rr_pick: a 2-way picker with a registered pointer (inputs req[1:0] and advance; output winner). It is instantiated once for read and once for write, and honours AXI_LITE_ARB_FIXED_PRIO_EN.

## Test plan
- Single write, s0 only: awaddr=0x10, wdata=0xA5, wstrb=1. Result: m sees the same values one cycle after the request; bresp=OKAY is returned to s0; s1 sees no bvalid.
- Simultaneous writes from s0 (0x04) and s1 (0x08) after reset: s0 is served first, then s1. With AXI_LITE_ARB_FIXED_PRIO_EN and s0 requesting continuously, s1 is starved.
- AW before W: s1 asserts AW at cycle 1 and W at cycle 4. Result: m.awvalid is asserted exactly once and deasserted after its handshake; W is forwarded at cycle 4; B is routed to s1.
- Concurrent traffic: s0 reads 0x20 while s1 writes 0x30=0x5A. Result: both complete; rdata reaches s0 only; bresp reaches s1 only.
- Downstream backpressure: m.rvalid is held for 5 cycles while s0's rready is low. Result: the grant is held and a pending s1 arvalid is not accepted until s0's R handshake.
- rst_n pulsed low during W_RESP: all outputs are 0 within the reset window, and the next s1 write is granted normally.

Source files
------------

// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the 2x1 AXI-Lite arbiter.
package axi_lite_arb_pkg;

   // Write path: address/data phase, then response phase
   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_XFER = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   // Read path: address phase, then data phase
   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } r_state_t;

   // Index of an upstream requester (0 or 1)
   typedef logic req_idx_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_arbiter_2x1_if.sv
// AXI-Lite bundle. Master drives requests, Slave drives ready/responses.
interface axi_lite_interface #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport Master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport Slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi_lite_arbiter_2x1_rr_pick.sv
// 2-way requester picker. Round-robin pointer by default;
// with AXI_LITE_ARB_FIXED_PRIO_EN defined, requester 0 always wins ties.
module axi_lite_rr_pick
   import axi_lite_arb_pkg::*;
(
`ifndef AXI_LITE_ARB_FIXED_PRIO_EN
   input  logic     clk,
   input  logic     rst_n,
   input  logic     advance,
   input  req_idx_t served,
`endif
   input  logic [1:0] req,
   output req_idx_t   winner
);

`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
   // Requester 1 wins only when it is alone
   assign winner = req_idx_t'(req[1] & ~req[0]);
`else
   req_idx_t ptr_q;
   req_idx_t ptr_d;

   // After a completed transaction, favour the requester that was not served
   always_comb begin
      ptr_d = ptr_q;
      if (advance) ptr_d = ~served;
   end

   // Pointer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end

   assign winner = (req == 2'b11) ? ptr_q : req_idx_t'(req[1] & ~req[0]);
`endif

endmodule

// File: rtl/axi_lite_arbiter_2x1.sv
// Two-manager to one-subordinate AXI-Lite arbiter with independent read and
// write grants held until the response handshake.
// Build option: AXI_LITE_ARB_FIXED_PRIO_EN selects fixed priority (requester 0).
module axi_lite_arbiter_2x1
   import axi_lite_arb_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned DATA_WIDTH    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   axi_lite_interface.Slave   s0,
   axi_lite_interface.Slave   s1,
   axi_lite_interface.Master  m
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;

   // ---------------- write path ----------------
   w_state_t w_state_q, w_state_d;
   req_idx_t wgnt_q, wgnt_d;
   logic     aw_done_q, aw_done_d;
   logic     w_done_q, w_done_d;
   logic     w_adv;
   logic     [1:0] w_req;
   req_idx_t w_win;
   logic     w_xfer, w_resp;
   logic     aw_open, w_open;
   logic     sel_awvalid, sel_wvalid, sel_bready;

   assign w_req       = {s1.awvalid | s1.wvalid, s0.awvalid | s0.wvalid};
   assign w_xfer      = (w_state_q == W_XFER);
   assign w_resp      = (w_state_q == W_RESP);
   assign aw_open     = w_xfer & ~aw_done_q;
   assign w_open      = w_xfer & ~w_done_q;
   assign sel_awvalid = wgnt_q ? s1.awvalid : s0.awvalid;
   assign sel_wvalid  = wgnt_q ? s1.wvalid  : s0.wvalid;
   assign sel_bready  = wgnt_q ? s1.bready  : s0.bready;

   axi_lite_rr_pick u_w_pick (
`ifndef AXI_LITE_ARB_FIXED_PRIO_EN
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (w_adv),
      .served  (wgnt_q),
`endif
      .req     (w_req),
      .winner  (w_win)
   );

   // Write next-state: grant, track AW/W completion, release on B handshake
   always_comb begin
      w_state_d = w_state_q;
      wgnt_d    = wgnt_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      w_adv     = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (|w_req) begin
               wgnt_d    = w_win;
               w_state_d = W_XFER;
            end
         end
         W_XFER: begin
            aw_done_d = aw_done_q | (m.awvalid & m.awready);
            w_done_d  = w_done_q  | (m.wvalid  & m.wready);
            if (aw_done_d && w_done_d) w_state_d = W_RESP;
         end
         W_RESP: begin
            if (m.bvalid && m.bready) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               w_adv     = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Write state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         wgnt_q    <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         wgnt_q    <= wgnt_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign m.awaddr  = w_xfer ? (wgnt_q ? s1.awaddr : s0.awaddr) : {ADDRESS_WIDTH{1'b0}};
   assign m.awprot  = w_xfer ? (wgnt_q ? s1.awprot : s0.awprot) : 3'b000;
   assign m.awvalid = aw_open & sel_awvalid;
   assign m.wdata   = w_xfer ? (wgnt_q ? s1.wdata : s0.wdata) : {DATA_WIDTH{1'b0}};
   assign m.wstrb   = w_xfer ? (wgnt_q ? s1.wstrb : s0.wstrb) : {STRB_W{1'b0}};
   assign m.wvalid  = w_open & sel_wvalid;
   assign m.bready  = w_resp & sel_bready;

   assign s0.awready = aw_open & ~wgnt_q & m.awready;
   assign s1.awready = aw_open &  wgnt_q & m.awready;
   assign s0.wready  = w_open  & ~wgnt_q & m.wready;
   assign s1.wready  = w_open  &  wgnt_q & m.wready;
   assign s0.bvalid  = w_resp  & ~wgnt_q & m.bvalid;
   assign s1.bvalid  = w_resp  &  wgnt_q & m.bvalid;
   assign s0.bresp   = (w_resp & ~wgnt_q) ? m.bresp : 2'b00;
   assign s1.bresp   = (w_resp &  wgnt_q) ? m.bresp : 2'b00;

   // ---------------- read path ----------------
   r_state_t r_state_q, r_state_d;
   req_idx_t rgnt_q, rgnt_d;
   logic     r_adv;
   logic     [1:0] r_req;
   req_idx_t r_win;
   logic     r_addr, r_data;

   assign r_req  = {s1.arvalid, s0.arvalid};
   assign r_addr = (r_state_q == R_ADDR);
   assign r_data = (r_state_q == R_DATA);

   axi_lite_rr_pick u_r_pick (
`ifndef AXI_LITE_ARB_FIXED_PRIO_EN
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (r_adv),
      .served  (rgnt_q),
`endif
      .req     (r_req),
      .winner  (r_win)
   );

   // Read next-state: grant, forward AR, release on R handshake
   always_comb begin
      r_state_d = r_state_q;
      rgnt_d    = rgnt_q;
      r_adv     = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (|r_req) begin
               rgnt_d    = r_win;
               r_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            if (m.arvalid && m.arready) r_state_d = R_DATA;
         end
         R_DATA: begin
            if (m.rvalid && m.rready) begin
               r_adv     = 1'b1;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         rgnt_q    <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         rgnt_q    <= rgnt_d;
      end
   end

   assign m.araddr  = r_addr ? (rgnt_q ? s1.araddr : s0.araddr) : {ADDRESS_WIDTH{1'b0}};
   assign m.arprot  = r_addr ? (rgnt_q ? s1.arprot : s0.arprot) : 3'b000;
   assign m.arvalid = r_addr & (rgnt_q ? s1.arvalid : s0.arvalid);
   assign m.rready  = r_data & (rgnt_q ? s1.rready : s0.rready);

   assign s0.arready = r_addr & ~rgnt_q & m.arready;
   assign s1.arready = r_addr &  rgnt_q & m.arready;
   assign s0.rvalid  = r_data & ~rgnt_q & m.rvalid;
   assign s1.rvalid  = r_data &  rgnt_q & m.rvalid;
   assign s0.rdata   = (r_data & ~rgnt_q) ? m.rdata : {DATA_WIDTH{1'b0}};
   assign s1.rdata   = (r_data &  rgnt_q) ? m.rdata : {DATA_WIDTH{1'b0}};
   assign s0.rresp   = (r_data & ~rgnt_q) ? m.rresp : 2'b00;
   assign s1.rresp   = (r_data &  rgnt_q) ? m.rresp : 2'b00;

endmodule

// File: tb/tb_axi_lite_arbiter_2x1.sv
// Directed bench for axi_lite_arbiter_2x1: write/read routing, arbitration
// order, partial AW/W completion, backpressure and mid-transaction reset.
module tb_axi_lite_arbiter_2x1;
   import axi_lite_arb_pkg::*;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   axi_lite_interface #(.ADDR_W(8), .DATA_W(8)) s0 ();
   axi_lite_interface #(.ADDR_W(8), .DATA_W(8)) s1 ();
   axi_lite_interface #(.ADDR_W(8), .DATA_W(8)) m  ();

   axi_lite_arbiter_2x1 #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s0    (s0),
      .s1    (s1),
      .m     (m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Move to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      s0.awaddr = '0; s0.awprot = '0; s0.awvalid = 0; s0.wdata = '0; s0.wstrb = '0;
      s0.wvalid = 0; s0.bready = 0; s0.araddr = '0; s0.arprot = '0; s0.arvalid = 0; s0.rready = 0;
      s1.awaddr = '0; s1.awprot = '0; s1.awvalid = 0; s1.wdata = '0; s1.wstrb = '0;
      s1.wvalid = 0; s1.bready = 0; s1.araddr = '0; s1.arprot = '0; s1.arvalid = 0; s1.rready = 0;
      m.awready = 1; m.wready = 1; m.arready = 1;
      m.bvalid = 0; m.bresp = '0; m.rvalid = 0; m.rdata = '0; m.rresp = '0;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst_n  = 1'b0;
      clear_inputs();

      // ---- reset state ----
      repeat (2) cyc();
      chk("rst_s0_awready", 32'(s0.awready), 32'd0);
      chk("rst_m_awvalid",  32'(m.awvalid),  32'd0);
      chk("rst_m_arvalid",  32'(m.arvalid),  32'd0);
      chk("rst_m_bready",   32'(m.bready),   32'd0);
      chk("rst_s0_bvalid",  32'(s0.bvalid),  32'd0);
      chk("rst_s1_rdata",   32'(s1.rdata),   32'd0);
      rst_n = 1'b1;

      // ---- single write from s0 ----
      s0.awaddr = 8'h10; s0.awvalid = 1; s0.wdata = 8'hA5; s0.wstrb = 1'b1; s0.wvalid = 1; s0.bready = 1;
      #1;
      chk("w1_idle_no_comb", 32'(m.awvalid), 32'd0);
      cyc();
      #1;
      chk("w1_m_awvalid", 32'(m.awvalid), 32'd1);
      chk("w1_m_awaddr",  32'(m.awaddr),  32'h10);
      chk("w1_m_wdata",   32'(m.wdata),   32'hA5);
      chk("w1_m_wstrb",   32'(m.wstrb),   32'h1);
      chk("w1_s0_awready", 32'(s0.awready), 32'd1);
      chk("w1_s1_awready", 32'(s1.awready), 32'd0);
      cyc();
      s0.awvalid = 0; s0.wvalid = 0;
      m.bvalid = 1; m.bresp = RESP_OKAY;
      #1;
      chk("w1_s0_bvalid", 32'(s0.bvalid), 32'd1);
      chk("w1_s0_bresp",  32'(s0.bresp),  32'(RESP_OKAY));
      chk("w1_s1_bvalid", 32'(s1.bvalid), 32'd0);
      chk("w1_m_bready",  32'(m.bready),  32'd1);
      cyc();
      m.bvalid = 0;
      #1;
      chk("w1_back_idle", 32'(m.awvalid), 32'd0);

      // ---- simultaneous writes after reset: s0 then s1 ----
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      s0.awaddr = 8'h04; s0.awvalid = 1; s0.wdata = 8'h11; s0.wvalid = 1; s0.wstrb = 1'b1; s0.bready = 1;
      s1.awaddr = 8'h08; s1.awvalid = 1; s1.wdata = 8'h22; s1.wvalid = 1; s1.wstrb = 1'b1; s1.bready = 1;
      cyc();
      #1;
      chk("w2_first_addr",  32'(m.awaddr),   32'h04);
      chk("w2_s0_awready",  32'(s0.awready), 32'd1);
      chk("w2_s1_awready",  32'(s1.awready), 32'd0);
      cyc();
      s0.awvalid = 0; s0.wvalid = 0;
      m.bvalid = 1; m.bresp = RESP_OKAY;
      #1;
      chk("w2_s0_bvalid", 32'(s0.bvalid), 32'd1);
      chk("w2_s1_bvalid", 32'(s1.bvalid), 32'd0);
      cyc();
      m.bvalid = 0;
      cyc();
      #1;
      chk("w2_second_addr", 32'(m.awaddr),   32'h08);
      chk("w2_second_data", 32'(m.wdata),    32'h22);
      chk("w2_s1_awready2", 32'(s1.awready), 32'd1);
      chk("w2_s0_awready2", 32'(s0.awready), 32'd0);
      cyc();
      s1.awvalid = 0; s1.wvalid = 0;
      m.bvalid = 1; m.bresp = RESP_SLVERR;
      #1;
      chk("w2_s1_bresp", 32'(s1.bresp), 32'(RESP_SLVERR));
      chk("w2_s0_bresp", 32'(s0.bresp), 32'd0);
      cyc();
      m.bvalid = 0; m.bresp = RESP_OKAY;

      // ---- s1: AW first, W three cycles later ----
      s1.awaddr = 8'h33; s1.awvalid = 1;
      cyc();
      #1;
      chk("w3_awvalid",     32'(m.awvalid), 32'd1);
      chk("w3_no_wvalid",   32'(m.wvalid),  32'd0);
      cyc();
      #1;
      chk("w3_aw_masked",   32'(m.awvalid),   32'd0);
      chk("w3_aw_rdy_mask", 32'(s1.awready),  32'd0);
      cyc();
      #1;
      chk("w3_still_masked", 32'(m.awvalid), 32'd0);
      cyc();
      s1.awvalid = 0; s1.wdata = 8'h77; s1.wvalid = 1;
      #1;
      chk("w3_m_wvalid",  32'(m.wvalid),  32'd1);
      chk("w3_m_wdata",   32'(m.wdata),   32'h77);
      chk("w3_s1_wready", 32'(s1.wready), 32'd1);
      cyc();
      s1.wvalid = 0;
      m.bvalid = 1;
      #1;
      chk("w3_s1_bvalid", 32'(s1.bvalid), 32'd1);
      chk("w3_s0_bvalid", 32'(s0.bvalid), 32'd0);
      cyc();
      m.bvalid = 0;

      // ---- concurrent: s0 reads 0x20, s1 writes 0x30=0x5A ----
      s0.araddr = 8'h20; s0.arvalid = 1; s0.rready = 1;
      s1.awaddr = 8'h30; s1.awvalid = 1; s1.wdata = 8'h5A; s1.wvalid = 1;
      cyc();
      #1;
      chk("c_m_araddr",  32'(m.araddr),  32'h20);
      chk("c_m_arvalid", 32'(m.arvalid), 32'd1);
      chk("c_m_awaddr",  32'(m.awaddr),  32'h30);
      chk("c_m_wdata",   32'(m.wdata),   32'h5A);
      cyc();
      s0.arvalid = 0; s1.awvalid = 0; s1.wvalid = 0;
      m.rvalid = 1; m.rdata = 8'hC3; m.rresp = RESP_OKAY; m.bvalid = 1;
      #1;
      chk("c_s0_rdata",  32'(s0.rdata),  32'hC3);
      chk("c_s0_rvalid", 32'(s0.rvalid), 32'd1);
      chk("c_s1_rdata",  32'(s1.rdata),  32'd0);
      chk("c_s1_rvalid", 32'(s1.rvalid), 32'd0);
      chk("c_s1_bvalid", 32'(s1.bvalid), 32'd1);
      chk("c_s0_bvalid", 32'(s0.bvalid), 32'd0);
      cyc();
      m.rvalid = 0; m.bvalid = 0; m.rdata = '0;

      // ---- R backpressure holds the read grant ----
      s0.araddr = 8'h40; s0.arvalid = 1; s0.rready = 0;
      cyc();
      cyc();
      s0.arvalid = 0;
      s1.araddr = 8'h44; s1.arvalid = 1; s1.rready = 1;
      m.rvalid = 1; m.rdata = 8'h99;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_s1_arready", 32'(s1.arready), 32'd0);
         chk("bp_m_rready",   32'(m.rready),   32'd0);
         chk("bp_s0_rvalid",  32'(s0.rvalid),  32'd1);
         cyc();
      end
      s0.rready = 1;
      #1;
      chk("bp_release_rready", 32'(m.rready), 32'd1);
      cyc();
      m.rvalid = 0;
      #1;
      chk("bp_idle_arready", 32'(s1.arready), 32'd0);
      cyc();
      #1;
      chk("bp_s1_araddr",  32'(m.araddr),   32'h44);
      chk("bp_s1_arready2", 32'(s1.arready), 32'd1);
      cyc();
      s1.arvalid = 0;
      m.rvalid = 1; m.rdata = 8'h55;
      #1;
      chk("bp_s1_rdata", 32'(s1.rdata), 32'h55);
      chk("bp_s0_rdata", 32'(s0.rdata), 32'd0);
      cyc();
      m.rvalid = 0;

      // ---- reset pulse during W_RESP ----
      s0.awaddr = 8'h60; s0.awvalid = 1; s0.wdata = 8'h66; s0.wvalid = 1; s0.bready = 1;
      cyc();
      cyc();
      s0.awvalid = 0; s0.wvalid = 0;
      m.bvalid = 1;
      #1;
      chk("rr_pre_bvalid", 32'(s0.bvalid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rr_s0_bvalid", 32'(s0.bvalid), 32'd0);
      chk("rr_m_bready",  32'(m.bready),  32'd0);
      chk("rr_m_awvalid", 32'(m.awvalid), 32'd0);
      m.bvalid = 0;
      cyc();
      rst_n = 1'b1;
      s1.awaddr = 8'h50; s1.awvalid = 1; s1.wdata = 8'h0F; s1.wvalid = 1; s1.bready = 1;
      cyc();
      #1;
      chk("rr_s1_awaddr",  32'(m.awaddr),   32'h50);
      chk("rr_s1_awready", 32'(s1.awready), 32'd1);
      cyc();
      s1.awvalid = 0; s1.wvalid = 0;
      m.bvalid = 1;
      #1;
      chk("rr_s1_bvalid", 32'(s1.bvalid), 32'd1);
      cyc();
      m.bvalid = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
